health_relay_sched: RTL and testbench



---
 rtl/health_pkg.sv | 20 ++
 rtl/health_relay_sched_if.sv | 25 ++
 rtl/fault_debounce.sv | 30 +++
 rtl/health_relay_sched.sv | 146 ++++++++++++++
 tb/tb_health_relay_sched.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/health_pkg.sv
// Shared types and defaults for the health relay scheduler.
package health_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StTrip,
        StWaitAck
    } state_e;

    localparam int unsigned DefNCh       = 4;
    localparam int unsigned DefDebounce  = 8;
    localparam int unsigned DefHold      = 16;
    localparam int unsigned DefBlinkDiv  = 4;

    // Width of a channel index; never narrower than one bit.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/health_relay_sched_if.sv
// Sensor-side and relay-side signals of the health relay scheduler.
interface health_relay_sched_if #(
    parameter int unsigned N_CH = health_pkg::DefNCh
);
    localparam int unsigned CH_W = health_pkg::ch_width(N_CH);

    logic [N_CH-1:0] fault_raw;
    logic            ack;
    logic            relay_driver;
    logic            light;
    logic [CH_W-1:0] active_ch;
    logic [N_CH-1:0] fault_pending;
    logic            busy;

    modport slave (
        input  fault_raw, ack,
        output relay_driver, light, active_ch, fault_pending, busy
    );

    modport master (
        output fault_raw, ack,
        input  relay_driver, light, active_ch, fault_pending, busy
    );

endinterface

// File: rtl/fault_debounce.sv
// Per-channel debounce counter; pulses o_confirm on the edge the count reaches DEBOUNCE.
module fault_debounce
    import health_pkg::*;
#(
    parameter int unsigned DEBOUNCE = DefDebounce
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_confirm
);

    localparam logic [7:0] CntMax = 8'(DEBOUNCE);

    logic [7:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (!i_raw) begin
            r_cnt <= '0;
        end else if (r_cnt != CntMax) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Saturation blocks further pulses until the input drops.
    assign o_confirm = i_raw && (r_cnt == CntMax - 8'd1);

endmodule

// File: rtl/health_relay_sched.sv
// Round-robin fault scheduler driving one shared relay and indicator light.
// Optional blinking light in WAIT_ACK is enabled by defining HEALTH_SCHED_BLINK_EN.
module health_relay_sched
    import health_pkg::*;
#(
    parameter int unsigned N_CH      = DefNCh,
    parameter int unsigned DEBOUNCE  = DefDebounce,
    parameter int unsigned HOLD      = DefHold,
    parameter int unsigned BLINK_DIV = DefBlinkDiv
) (
    input  logic                 clk,
    input  logic                 reset,
    health_relay_sched_if.slave  bus
);

    localparam int unsigned CH_W     = ch_width(N_CH);
    localparam logic [15:0] HoldLast = 16'(HOLD - 1);

    if (N_CH < 2 || N_CH > 8 || DEBOUNCE < 1 || DEBOUNCE > 255 || HOLD < 1 || HOLD > 65535
        || BLINK_DIV < 1) begin : g_bad_param
        $error("health_relay_sched: parameter out of range");
    end

    logic [N_CH-1:0] w_confirm;
    logic [N_CH-1:0] w_clr;
    logic [N_CH-1:0] r_pending;
    state_e          r_state;
    logic [CH_W-1:0] r_active;
    logic [CH_W-1:0] r_rr_ptr;
    logic [15:0]     r_hold;
    logic            r_relay;
    logic            r_light;
    logic            r_busy;
    logic            w_found;
    logic [CH_W-1:0] w_sel;
    logic [CH_W:0]   w_idx;
    logic [CH_W-1:0] w_next_ptr;
    logic            w_ack_done;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_deb
        fault_debounce #(
            .DEBOUNCE (DEBOUNCE)
        ) u_deb (
            .clk       (clk),
            .reset     (reset),
            .i_raw     (bus.fault_raw[gi]),
            .o_confirm (w_confirm[gi])
        );
    end

    // First pending channel at or above rr_ptr, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (CH_W + 1)'(k);
            if (w_idx >= (CH_W + 1)'(N_CH)) begin
                w_idx = w_idx - (CH_W + 1)'(N_CH);
            end
            if (!w_found && r_pending[w_idx[CH_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_idx[CH_W-1:0];
            end
        end
    end

    always_comb begin
        w_ack_done = (r_state == StWaitAck) && bus.ack;
        w_clr      = w_ack_done ? (N_CH'(1) << r_active) : '0;
        w_next_ptr = (r_active == CH_W'(N_CH - 1)) ? '0 : r_active + CH_W'(1);
    end

`ifdef HEALTH_SCHED_BLINK_EN
    localparam logic [15:0] BlinkLast = 16'(BLINK_DIV - 1);
    logic [15:0] r_blink;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= StIdle;
            r_active  <= '0;
            r_rr_ptr  <= '0;
            r_hold    <= '0;
            r_relay   <= 1'b0;
            r_light   <= 1'b0;
            r_busy    <= 1'b0;
            r_pending <= '0;
`ifdef HEALTH_SCHED_BLINK_EN
            r_blink   <= '0;
`endif
        end else begin
            // A confirm on the bit being acknowledged keeps it set.
            r_pending <= (r_pending & ~w_clr) | w_confirm;
            unique case (r_state)
                StIdle: begin
                    if (w_found) begin
                        r_state  <= StTrip;
                        r_active <= w_sel;
                        r_hold   <= '0;
                        r_relay  <= 1'b1;
                        r_light  <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                StTrip: begin
                    if (r_hold == HoldLast) begin
                        r_state <= StWaitAck;
                        r_light <= 1'b1;
`ifdef HEALTH_SCHED_BLINK_EN
                        r_blink <= '0;
`endif
                    end else begin
                        r_hold <= r_hold + 16'd1;
                    end
                end
                StWaitAck: begin
                    if (bus.ack) begin
                        r_state  <= StIdle;
                        r_active <= '0;
                        r_rr_ptr <= w_next_ptr;
                        r_relay  <= 1'b0;
                        r_light  <= 1'b0;
                        r_busy   <= 1'b0;
                    end
`ifdef HEALTH_SCHED_BLINK_EN
                    else if (r_blink == BlinkLast) begin
                        r_blink <= '0;
                        r_light <= ~r_light;
                    end else begin
                        r_blink <= r_blink + 16'd1;
                    end
`endif
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.relay_driver  = r_relay;
    assign bus.light         = r_light;
    assign bus.active_ch     = r_active;
    assign bus.fault_pending = r_pending;
    assign bus.busy          = r_busy;

endmodule

// File: tb/tb_health_relay_sched.sv
// Self-checking bench for health_relay_sched: vector table, directed corners, random vs model.
module tb_health_relay_sched;

    localparam int N  = 4;
    localparam int D  = 3;
    localparam int H  = 4;
    localparam int BD = 2;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    health_relay_sched_if #(.N_CH(N)) bus ();

    health_relay_sched #(
        .N_CH      (N),
        .DEBOUNCE  (D),
        .HOLD      (H),
        .BLINK_DIV (BD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: debounce counts, pending set, current grant and its age.
    int       m_cnt [N];
    bit [3:0] m_pend;
    int       m_grant;
    int       m_since;
    int       m_rr;

    task automatic model_step(input logic [3:0] raw, input logic ack, input logic rstn);
        bit [3:0] conf;
        bit [3:0] clr;
        conf = '0;
        clr  = '0;
        if (!rstn) begin
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            m_pend  = '0;
            m_grant = -1;
            m_since = 0;
            m_rr    = 0;
            return;
        end
        for (int i = 0; i < N; i++) begin
            conf[i]  = raw[i] && (m_cnt[i] == D - 1);
            m_cnt[i] = raw[i] ? ((m_cnt[i] + 1 > D) ? D : m_cnt[i] + 1) : 0;
        end
        if (m_grant < 0) begin
            for (int k = 0; k < N; k++) begin
                if (m_grant < 0 && m_pend[(m_rr + k) % N]) begin
                    m_grant = (m_rr + k) % N;
                    m_since = 0;
                end
            end
        end else if (m_since >= H && ack) begin
            clr[m_grant] = 1'b1;
            m_rr    = (m_grant + 1) % N;
            m_grant = -1;
        end else begin
            m_since++;
        end
        m_pend = (m_pend & ~clr) | conf;
    endtask

    function automatic bit model_light();
        if (m_grant < 0) return 1'b0;
        if (m_since < H) return 1'b1;
`ifdef HEALTH_SCHED_BLINK_EN
        return (((m_since - H) / BD) % 2) == 0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("relay", 32'(bus.relay_driver), 32'(m_grant >= 0));
        chk("light", 32'(bus.light), 32'(model_light()));
        chk("active_ch", 32'(bus.active_ch), 32'((m_grant >= 0) ? m_grant : 0));
        chk("pending", 32'(bus.fault_pending), 32'(m_pend));
        chk("busy", 32'(bus.busy), 32'(m_grant >= 0));
    endtask

    task automatic step(input logic [3:0] raw, input logic ack, input logic rstn);
        bus.fault_raw = raw;
        bus.ack       = ack;
        reset         = rstn;
        @(posedge clk);
        model_step(raw, ack, rstn);
        #1;
        compare_model();
    endtask

    // Remainder of a grant after its first cycle: finish TRIP, one WAIT_ACK cycle, then ack.
    task automatic serve(input logic [3:0] raw);
        repeat (H) step(raw, 1'b0, 1'b1);
        step(raw, 1'b1, 1'b1);
    endtask

    typedef struct {
        logic [3:0] raw;
        logic       ack;
        logic       rstn;
        logic       relay;
        logic       light;
        logic [1:0] act;
        logic [3:0] pend;
        logic       busy;
    } vec_t;

    vec_t       tbl [14];
    logic [5:0] lp;
    logic [5:0] exp_pat;
    logic [3:0] rnd_raw;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        bus.fault_raw = '0;
        bus.ack       = 1'b0;
        reset         = 1'b0;
        m_grant       = -1;

        //          raw    ack   rstn  relay light act   pend   busy
        tbl[0]  = '{4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0};
        tbl[1]  = '{4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0};
        tbl[2]  = '{4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0};
        tbl[3]  = '{4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0};
        tbl[4]  = '{4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0};
        tbl[5]  = '{4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0};
        tbl[6]  = '{4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'h2, 1'b0};
        tbl[7]  = '{4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 4'h2, 1'b1};
        tbl[8]  = '{4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 4'h2, 1'b1};
        tbl[9]  = '{4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 4'h2, 1'b1};
        tbl[10] = '{4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 4'h2, 1'b1};
        tbl[11] = '{4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 4'h2, 1'b1};
        tbl[12] = '{4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0};
        tbl[13] = '{4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0};

        for (int i = 0; i < 14; i++) begin
            bus.fault_raw = tbl[i].raw;
            bus.ack       = tbl[i].ack;
            reset         = tbl[i].rstn;
            @(posedge clk);
            model_step(tbl[i].raw, tbl[i].ack, tbl[i].rstn);
            #1;
            chk($sformatf("vec%0d_relay", i), 32'(bus.relay_driver), 32'(tbl[i].relay));
            chk($sformatf("vec%0d_light", i), 32'(bus.light), 32'(tbl[i].light));
            chk($sformatf("vec%0d_act", i), 32'(bus.active_ch), 32'(tbl[i].act));
            chk($sformatf("vec%0d_pend", i), 32'(bus.fault_pending), 32'(tbl[i].pend));
            chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(tbl[i].busy));
        end

        // Round-robin: ch0 and ch2 together from rr=0, then ch0/ch3 with rr=3.
        step(4'h0, 1'b0, 1'b0);
        repeat (D) step(4'h5, 1'b0, 1'b1);
        chk("rr_pend_both", 32'(bus.fault_pending), 32'h5);
        step(4'h0, 1'b0, 1'b1);
        chk("rr_first_ch0", 32'(bus.active_ch), 32'd0);
        serve(4'h0);
        step(4'h0, 1'b0, 1'b1);
        chk("rr_then_ch2", 32'(bus.active_ch), 32'd2);
        repeat (D) step(4'h9, 1'b0, 1'b1);
        step(4'h0, 1'b0, 1'b1);
        chk("rr_latch_during_grant", 32'(bus.fault_pending), 32'hD);
        step(4'h0, 1'b1, 1'b1);
        step(4'h0, 1'b0, 1'b1);
        chk("rr_wrap_ch3_first", 32'(bus.active_ch), 32'd3);
        serve(4'h0);
        step(4'h0, 1'b0, 1'b1);
        chk("rr_wrap_then_ch0", 32'(bus.active_ch), 32'd0);
        serve(4'h0);

        // Collision: ack lands on the edge ch1 re-confirms.
        repeat (D) step(4'h2, 1'b0, 1'b1);
        step(4'h0, 1'b0, 1'b1);
        chk("col_grant_ch1", 32'(bus.active_ch), 32'd1);
        repeat (H - 1) step(4'h0, 1'b0, 1'b1);
        step(4'h2, 1'b0, 1'b1);
        step(4'h2, 1'b0, 1'b1);
        step(4'h2, 1'b1, 1'b1);
        chk("col_set_wins", 32'(bus.fault_pending), 32'h2);
        chk("col_idle", 32'(bus.relay_driver), 32'd0);
        step(4'h0, 1'b0, 1'b1);
        chk("col_reserve_ch1", 32'(bus.active_ch), 32'd1);
        serve(4'h0);

        // Blink pattern in WAIT_ACK, then reset mid-grant with the fault still high.
        repeat (D) step(4'h4, 1'b0, 1'b1);
        step(4'h4, 1'b0, 1'b1);
        repeat (H) step(4'h4, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step(4'h4, 1'b0, 1'b1);
            lp[i] = bus.light;
        end
`ifdef HEALTH_SCHED_BLINK_EN
        exp_pat = 6'b110011;
`else
        exp_pat = 6'b111111;
`endif
        for (int i = 0; i < 6; i++) chk($sformatf("light_wait%0d", i), 32'(lp[i]), 32'(exp_pat[i]));
        step(4'h4, 1'b0, 1'b0);
        chk("rst_relay", 32'(bus.relay_driver), 32'd0);
        chk("rst_light", 32'(bus.light), 32'd0);
        chk("rst_pend", 32'(bus.fault_pending), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        repeat (D - 1) step(4'h4, 1'b0, 1'b1);
        chk("rst_no_early_confirm", 32'(bus.fault_pending), 32'd0);
        step(4'h4, 1'b0, 1'b1);
        chk("rst_reconfirm", 32'(bus.fault_pending), 32'h4);
        step(4'h0, 1'b0, 1'b1);
        chk("rst_regrant", 32'(bus.relay_driver), 32'd1);

        // Random traffic against the model.
        rnd_raw = '0;
        for (int c = 0; c < 3000; c++) begin
            rnd_raw = rnd_raw ^ (4'($urandom) & 4'($urandom));
            step(rnd_raw, $urandom_range(0, 2) == 0, $urandom_range(0, 299) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
